// File: rtl/dmem_responder_if.sv
// Data-port bundle between the MEM stage (master) and the data memory responder (slave).
interface dmem_responder_if;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wdata, mem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wdata, mem_byte_enable,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: captures one request, completes it LATENCY cycles later
// with a one-cycle resp pulse, applying byte-enabled writes or returning a read word.
module dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    resp_q, resp_d;
    logic                    enter_resp_s;
    logic [31:0]             mem_q [2**ADDR_WIDTH];
    logic                    unused_addr_bits_s;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign unused_addr_bits_s = &{1'b0, bus.dmem_address[31:ADDR_WIDTH+2], bus.dmem_address[1:0]};

    // Next-state, capture and completion logic; *_d carries the live transaction so LATENCY==1 works
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        enter_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dmem_read || bus.dmem_write) begin
                    idx_d   = bus.dmem_address[ADDR_WIDTH+1:2];
                    wr_d    = bus.dmem_write;
                    wdata_d = bus.dmem_wdata;
                    be_d    = bus.mem_byte_enable;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resp_d = enter_resp_s;
        if (enter_resp_s && !wr_d) begin
            rdata_d = mem_q[idx_d];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
        end
    end

    // Storage array is deliberately not reset; a write commits on the edge entering RESP
    always_ff @(posedge clk) begin
        if (enter_resp_s && wr_d && !rst) begin
            mem_q[idx_d] <= merge_lanes(mem_q[idx_d], wdata_d, be_d);
        end
    end

    assign bus.dmem_rdata = rdata_q;
    assign bus.dmem_resp  = resp_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 2 (main), 1 and 4 sharing one stimulus bus.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  sel_r   = 3'b000;
    logic        rd_r    = 1'b0;
    logic        wr_r    = 1'b0;
    logic [31:0] addr_r  = 32'h0;
    logic [31:0] wdata_r = 32'h0;
    logic [3:0]  be_r    = 4'h0;

    dmem_responder_if bus2 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus4 ();

    assign bus2.dmem_address = addr_r;  assign bus1.dmem_address = addr_r;  assign bus4.dmem_address = addr_r;
    assign bus2.dmem_wdata   = wdata_r; assign bus1.dmem_wdata   = wdata_r; assign bus4.dmem_wdata   = wdata_r;
    assign bus2.mem_byte_enable = be_r; assign bus1.mem_byte_enable = be_r; assign bus4.mem_byte_enable = be_r;
    assign bus2.dmem_read  = rd_r & sel_r[0];
    assign bus2.dmem_write = wr_r & sel_r[0];
    assign bus1.dmem_read  = rd_r & sel_r[1];
    assign bus1.dmem_write = wr_r & sel_r[1];
    assign bus4.dmem_read  = rd_r & sel_r[2];
    assign bus4.dmem_write = wr_r & sel_r[2];

    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut_l2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    dmem_responder #(.ADDR_WIDTH(8), .LATENCY(4)) dut_l4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    logic [2:0]  resp_v;
    logic [31:0] rdata_v [3];
    assign resp_v     = {bus4.dmem_resp, bus1.dmem_resp, bus2.dmem_resp};
    assign rdata_v[0] = bus2.dmem_rdata;
    assign rdata_v[1] = bus1.dmem_rdata;
    assign rdata_v[2] = bus4.dmem_rdata;

    typedef struct {
        int          dut;
        int          exp_cyc;
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   resp_cnt [3] = '{0, 0, 0};
    logic [2:0] prev_resp = 3'b000;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every resp pulse
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (resp_v[k]) begin
                    resp_cnt[k]++;
                    if (prev_resp[k]) check_val("resp_double", 32'(prev_resp[k]), 32'd0);
                    if (sb_q.size() == 0) begin
                        check_val("resp_spurious", 32'(resp_v[k]), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check_val("resp_dut", 32'(k), 32'(e.dut));
                        check_val("resp_cycle", 32'(cyc), 32'(e.exp_cyc));
                        if (e.is_read) check_val("rdata", rdata_v[k], e.data);
                    end
                end
            end
        end
        prev_resp = resp_v;
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic txn(input int k, input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp_rd);
        int base;
        @(negedge clk);
        sel_r   = 3'b001 << k;
        addr_r  = a;
        wr_r    = w;
        rd_r    = r;
        wdata_r = d;
        be_r    = be;
        base    = resp_cnt[k];
        sb_q.push_back('{dut: k, exp_cyc: cyc + lat_of(k), is_read: (r && !w), data: exp_rd});
        for (int i = 0; i < 20 && resp_cnt[k] == base; i++) begin
            @(negedge clk);
            #1;
        end
        rd_r = 1'b0;
        wr_r = 1'b0;
        if (resp_cnt[k] == base) begin
            check_val("resp_timeout", 32'(resp_cnt[k]), 32'(base + 1));
            if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        end
    endtask

    initial begin
        int c;
        logic [7:0] pat;

        // Asynchronous reset between edges
        #12 rst = 1'b1;
        #1;
        check_val("rst_resp", 32'(bus2.dmem_resp), 32'd0);
        check_val("rst_rdata", bus2.dmem_rdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("idle_no_resp", 32'(resp_v), 32'd0);
        end

        // Write then read at LATENCY 2
        txn(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'b1111, 32'h0);
        txn(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'b0000, 32'hDEADBEEF);

        // Byte-enable merge and empty mask
        txn(0, 1'b1, 1'b0, 32'h80, 32'h11223344, 4'b1111, 32'h0);
        txn(0, 1'b1, 1'b0, 32'h80, 32'hAABBCCDD, 4'b0100, 32'h0);
        txn(0, 1'b0, 1'b1, 32'h80, 32'h0, 4'b1111, 32'h11BB3344);
        txn(0, 1'b1, 1'b0, 32'h80, 32'h99999999, 4'b0000, 32'h0);
        txn(0, 1'b0, 1'b1, 32'h80, 32'h0, 4'b0000, 32'h11BB3344);

        // Read and write together behave as a write; rdata untouched
        txn(0, 1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 4'b1111, 32'h0);
        check_val("rw_rdata_hold", bus2.dmem_rdata, 32'h11BB3344);
        txn(0, 1'b0, 1'b1, 32'h80, 32'h0, 4'b0000, 32'hCAFEF00D);

        // Read held continuously: pulses every LATENCY+1 cycles
        @(negedge clk);
        sel_r  = 3'b001;
        addr_r = 32'h40;
        rd_r   = 1'b1;
        c      = cyc;
        for (int j = 0; j < 3; j++) sb_q.push_back('{dut: 0, exp_cyc: c + 2 + 3 * j, is_read: 1'b1, data: 32'hDEADBEEF});
        pat = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            pat[i-1] = bus2.dmem_resp;
            if (i == 3 || i == 4 || i == 6 || i == 7) check_val("held_rdata", bus2.dmem_rdata, 32'hDEADBEEF);
        end
        rd_r = 1'b0;
        check_val("held_pattern", 32'(pat), 32'h92);

        // Reset in the middle of BUSY aborts the write
        txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h0);
        @(negedge clk);
        addr_r  = 32'h10;
        wdata_r = 32'h55;
        be_r    = 4'b1111;
        wr_r    = 1'b1;
        @(negedge clk);
        wr_r = 1'b0;
        rst  = 1'b1;
        #1;
        check_val("midbusy_resp", 32'(bus2.dmem_resp), 32'd0);
        check_val("midbusy_rdata", bus2.dmem_rdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'b0000, 32'h0);

        // LATENCY 1 with address aliasing
        txn(1, 1'b1, 1'b0, 32'h400, 32'h13579BDF, 4'b1111, 32'h0);
        txn(1, 1'b0, 1'b1, 32'h000, 32'h0, 4'b0000, 32'h13579BDF);

        // LATENCY 4
        txn(2, 1'b1, 1'b0, 32'h0C, 32'h2468ACE0, 4'b1111, 32'h0);
        txn(2, 1'b0, 1'b1, 32'h0C, 32'h0, 4'b0000, 32'h2468ACE0);

        repeat (6) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
